// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store masters
// Define MEM_ARB_LS_PRIO_EN for fixed load/store priority; default build is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              win_ls_q, win_we_q;
  logic              if_gnt_q, ls_gnt_q, if_rvalid_q, ls_rvalid_q;
  logic              mem_req_q, mem_we_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, ls_rdata_q;
  logic              any_req, arb_en, pick_ls;
  logic [ADDR_W-1:0] sel_addr;

  assign any_req  = if_req | ls_req;
  assign arb_en   = (state_q == S_IDLE) || (state_q == S_RESP);
  assign sel_addr = (pick_ls ? ls_addr : if_addr) & ~ADDR_W'(3);

`ifdef MEM_ARB_LS_PRIO_EN
  assign pick_ls = ls_req;
`else
  // last_ls_q records who won the previous arbitration; the other master wins a tie.
  logic last_ls_q;
  assign pick_ls = ls_req & (~if_req | ~last_ls_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 last_ls_q <= 1'b0;
    else if (arb_en && any_req) last_ls_q <= pick_ls;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      default: state_d = any_req ? S_ISSUE : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_ls_q    <= 1'b0;
      win_we_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      // Grant and memory strobe are registered, so they appear in the ISSUE cycle.
      if (arb_en && any_req) begin
        win_ls_q    <= pick_ls;
        win_we_q    <= pick_ls & ls_we;
        if_gnt_q    <= ~pick_ls;
        ls_gnt_q    <= pick_ls;
        mem_req_q   <= 1'b1;
        mem_we_q    <= pick_ls & ls_we;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= pick_ls ? ls_wdata : '0;
      end
      if (state_q == S_ISSUE) cnt_q <= CNT_W'(MEM_LAT - 1);
      if (state_q == S_WAIT) begin
        if (cnt_q == '0) begin
          if (win_ls_q) begin
            ls_rvalid_q <= 1'b1;
            ls_rdata_q  <= win_we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: read data is only driven in the cycle exactly LAT after mem_req.
  logic [31:0] mem [256] = '{default: '0};
  logic        vpipe [LAT] = '{default: 1'b0};
  logic [31:0] dpipe [LAT] = '{default: '0};

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      vpipe[i] <= vpipe[i-1];
      dpipe[i] <= dpipe[i-1];
    end
    vpipe[0] <= mem_req && !mem_we;
    dpipe[0] <= mem[mem_addr[9:2]];
    if (mem_req && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  assign mem_rdata = vpipe[LAT-1] ? dpipe[LAT-1] : 32'hBAD0_BAD0;

  typedef struct {
    bit          ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[9];
  logic [31:0] if_rd_exp, ls_rd_exp;
  bit          if_known, ls_known;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if_req = !v.ls; if_addr = v.addr;
    ls_req = v.ls;  ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
    step();
    chk($sformatf("v%0d if_gnt", idx), {31'b0, if_gnt}, {31'b0, !v.ls});
    chk($sformatf("v%0d ls_gnt", idx), {31'b0, ls_gnt}, {31'b0, v.ls});
    chk($sformatf("v%0d mem_req", idx), {31'b0, mem_req}, 32'd1);
    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_maddr);
    chk($sformatf("v%0d mem_we", idx), {31'b0, mem_we}, {31'b0, v.we});
    if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
    if_req = 1'b0; ls_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      chk($sformatf("v%0d wait%0d req/rvalid", idx, k), {29'b0, mem_req, if_rvalid, ls_rvalid}, 32'd0);
      chk($sformatf("v%0d wait%0d busy", idx, k), {31'b0, busy}, 32'd1);
    end
    step();
    chk($sformatf("v%0d if_rvalid", idx), {31'b0, if_rvalid}, {31'b0, !v.ls});
    chk($sformatf("v%0d ls_rvalid", idx), {31'b0, ls_rvalid}, {31'b0, v.ls});
    if (v.ls) begin
      ls_rd_exp = v.exp_rdata; ls_known = 1'b1;
    end else begin
      if_rd_exp = v.exp_rdata; if_known = 1'b1;
    end
    if (if_known) chk($sformatf("v%0d if_rdata", idx), if_rdata, if_rd_exp);
    if (ls_known) chk($sformatf("v%0d ls_rdata", idx), ls_rdata, ls_rd_exp);
    step();
    chk($sformatf("v%0d idle busy/rvalid", idx), {29'b0, busy, if_rvalid, ls_rvalid}, 32'd0);
  endtask

  // Holds the selected requests continuously; pat bit g = 1 means grant g must go to load/store.
  task automatic stream(input string tag, input bit use_if, input bit use_ls, input int n, input bit [7:0] pat);
    int  c, last_c;
    bit  got;
    if_req = use_if; if_addr = 32'h4;
    ls_req = use_ls; ls_we = 1'b0; ls_addr = 32'h0;
    c = 0; last_c = 0;
    for (int g = 0; g < n; g++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        step(); c++;
        if (if_gnt || ls_gnt) got = 1'b1;
        else if (g > 0) chk($sformatf("%s busy before grant %0d", tag, g), {31'b0, busy}, 32'd1);
      end
      if (!got) begin
        n_vec++; n_bad++;
        $display("FAIL %s grant %0d timeout: got no grant expected grant within 20 cycles", tag, g);
        break;
      end
      chk($sformatf("%s grant %0d ls_gnt", tag, g), {31'b0, ls_gnt}, {31'b0, pat[g]});
      chk($sformatf("%s grant %0d if_gnt", tag, g), {31'b0, if_gnt}, {31'b0, !pat[g]});
      chk($sformatf("%s grant %0d cycle", tag, g), c - last_c, (g == 0) ? 1 : LAT + 2);
      last_c = c;
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (LAT + 2) step();
    chk($sformatf("%s drained busy", tag), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0050_0093, 32'h0000_0004, 32'h0000_0000};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0000};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0100, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0000_0000, 32'h0000_0100, 32'hDEAD_BEEF};
    tbl[6] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0100, 32'hDEAD_BEEF};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0000_0008, 32'h0000_0000};
    tbl[8] = '{1'b0, 1'b0, 32'h0000_000A, 32'h0000_0000, 32'h0000_0008, 32'h1234_5678};
    if_known = 1'b0; ls_known = 1'b0;
    if_rd_exp = '0; ls_rd_exp = '0;

    repeat (3) step();
    chk("reset ctrl outs", {25'b0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset ls_rdata", ls_rdata, 32'd0);
    rst_n = 1'b1;

`ifdef MEM_ARB_LS_PRIO_EN
    stream("tie", 1'b1, 1'b1, 4, 8'b0000_1111);
`else
    stream("tie", 1'b1, 1'b1, 4, 8'b0000_0101);
`endif

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    stream("b2b fetch", 1'b1, 1'b0, 3, 8'b0000_0000);

    // Reset asserted during WAIT must kill the transaction without an rvalid.
    if_req = 1'b1; if_addr = 32'h4;
    step();
    if_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midwait ctrl outs", {25'b0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy}, 32'd0);
    chk("midwait if_rdata", if_rdata, 32'd0);
    chk("midwait ls_rdata", ls_rdata, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      step();
      chk($sformatf("post reset cycle %0d", k), {29'b0, if_rvalid, ls_rvalid, busy}, 32'd0);
    end

`ifdef MEM_ARB_LS_PRIO_EN
    stream("tie after reset", 1'b1, 1'b1, 2, 8'b0000_0011);
`else
    stream("tie after reset", 1'b1, 1'b1, 2, 8'b0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-ported unified memory between the CPU instruction-fetch path (PC in, instruction out) and the load/store path (ALU result as address). It accepts requests from both masters, selects one per transaction, drives the memory port for exactly one cycle, waits a fixed memory latency, and returns the read data with a one-cycle valid pulse to the winner. It sits between the core and the memory model that the testbench drives.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MEM_LAT, 1, memory read latency in cycles from the mem_req cycle to valid mem_rdata; legal range 1..8

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  one-cycle grant pulse to fetch master
- if_rvalid  out  1  one-cycle pulse, if_rdata valid (instruction)
- if_rdata  out  DATA_W  fetched instruction
- ls_req  in  1  load/store request; held high with ls_we/ls_addr/ls_wdata stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address (ALU result)
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle grant pulse to load/store master
- ls_rvalid  out  1  one-cycle completion pulse; ls_rdata valid for loads
- ls_rdata  out  DATA_W  load data; 0 for stores
- mem_req  out  1  one-cycle memory strobe
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W  memory address, bits [1:0] forced to 0
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
- IDLE: if any req high, arbitrate, latch winner id, we, addr, wdata -> ISSUE; else stay.
- ISSUE (1 cycle): mem_req=1, mem_we/addr/wdata from latch, winner's gnt=1; load wait counter with MEM_LAT-1 -> WAIT.
- WAIT (MEM_LAT cycles): counter decrements; on counter==0 capture mem_rdata (0 if store) -> RESP.
- RESP (1 cycle): winner's rvalid=1 with captured data; requests sampled and arbitrated as in IDLE -> ISSUE if any req, else IDLE.
- Requests are ignored in ISSUE and WAIT; only one transaction outstanding.
- Arbitration: round-robin; on simultaneous if_req and ls_req the master not granted last wins; single requester always wins. Last-grant pointer resets to "fetch", so the first tie goes to load/store.
- rdata outputs hold last value between rvalid pulses; only the winner's rdata updates.
- Reset (any time, including mid-transaction): state IDLE, pointer = fetch, all outputs 0; an in-flight response is dropped, no rvalid issued.

## Timing
- Request seen in cycle N (IDLE) -> gnt and mem_req in N+1 -> mem_rdata sampled in N+1+MEM_LAT -> rvalid in N+2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles (RESP overlaps with next arbitration).
- Master must drop req in the cycle after it sees gnt unless it has a new request; a req still high in RESP is a new request.
- Wait counter width clog2(MEM_LAT+1); no wrap, reloads every ISSUE.

## Configuration
- MEM_ARB_LS_PRIO_EN defined: fixed priority, ls_req always beats if_req on ties; pointer not used.
- Undefined: round-robin as described above.

## Test plan
- Reset: rst_n low 3 cycles, mid-WAIT reassert -> all outputs 0, busy 0, no rvalid afterwards.
- Single fetch, MEM_LAT=1: if_req, if_addr=0x0000_0004 in cycle 0 -> if_gnt, mem_req, mem_addr=0x4 at cycle 1; memory returns 0x0050_0093 at cycle 2 -> if_rvalid, if_rdata=0x0050_0093 at cycle 3.
- Store then load, MEM_LAT=3: ls store 0xDEAD_BEEF to 0x100 -> mem_we=1, ls_rvalid at cycle 5 with ls_rdata=0; load 0x100 -> ls_rdata=0xDEAD_BEEF.
- Simultaneous if_req/ls_req held continuously from reset -> grants alternate ls, if, ls, if; with MEM_ARB_LS_PRIO_EN, ls granted every time while ls_req high.
- Misaligned if_addr=0x0000_0007 -> mem_addr=0x0000_0004.
- Back-to-back fetches, MEM_LAT=2 -> if_gnt every 4 cycles, busy never low between transactions.
